// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter and its seeker.
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 4;
  localparam int unsigned DEFAULT_STEP_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAN = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } seek_state_e;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } seek_dir_e;

  // Largest step a single pulse can carry.
  function automatic int unsigned max_step(input int unsigned step_w);
    return (32'd1 << step_w) - 32'd1;
  endfunction

endpackage

// File: rtl/counter_seeker.sv
// Drives an up/down counter to a requested target the short way round,
// issuing back-to-back step pulses while mirroring the counter value.
module counter_seeker #(
  parameter int unsigned WIDTH  = counter_pkg::DEFAULT_WIDTH,
  parameter int unsigned STEP_W = counter_pkg::DEFAULT_STEP_W
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [WIDTH-1:0]  start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WIDTH-1:0]  req_target,
  output logic              inc,
  output logic              dec,
  output logic [STEP_W-1:0] inc_step,
  output logic [WIDTH-1:0]  cur_val,
  output logic              busy,
  output logic              done
);
  import counter_pkg::*;

  localparam int unsigned MAX_STEP = max_step(STEP_W);

  seek_state_e       state_q, state_d;
  seek_dir_e         dir_q, dir_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  target_q, target_d;
  logic [WIDTH-1:0]  cur_q, cur_d;
  logic              inc_q, inc_d;
  logic              dec_q, dec_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  up_dist, down_dist;

  // Next state plus next-cycle outputs; outputs are derived from state_d so
  // every output is a flop that is valid for the whole of its cycle.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    rem_d    = rem_q;
    target_d = target_q;
    cur_d    = cur_q;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    step_d   = '0;

    up_dist   = target_q - cur_q;
    down_dist = cur_q - target_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          target_d = req_target;
          state_d  = PLAN;
        end
      end
      PLAN: begin
        if (down_dist < up_dist) begin
          dir_d = DIR_DEC;
          rem_d = down_dist;
        end else begin
          dir_d = DIR_INC;
          rem_d = up_dist;
        end
        state_d = (rem_d == '0) ? DONE : STEP;
      end
      STEP: begin
        if (dir_q == DIR_INC) cur_d = cur_q + WIDTH'(step_q);
        else                  cur_d = cur_q - WIDTH'(step_q);
        rem_d   = rem_q - WIDTH'(step_q);
        state_d = (rem_d == '0) ? DONE : STEP;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == STEP) begin
      inc_d = (dir_d == DIR_INC);
      dec_d = (dir_d == DIR_DEC);
      if (32'(rem_d) > MAX_STEP) step_d = STEP_W'(MAX_STEP);
      else                       step_d = STEP_W'(rem_d);
    end

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  // State and output registers; reset aborts any move and reloads the mirror.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dir_q    <= DIR_INC;
      rem_q    <= '0;
      target_q <= '0;
      cur_q    <= start;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      step_q   <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      rem_q    <= rem_d;
      target_q <= target_d;
      cur_q    <= cur_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      step_q   <= step_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign req_ready = ready_q;
  assign inc       = inc_q;
  assign dec       = dec_q;
  assign inc_step  = step_q;
  assign cur_val   = cur_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_counter_seeker.sv
// Directed bench for counter_seeker paired with a behavioural up/down counter.
module tb_counter_seeker;

  logic       clk_in;
  logic       rst;
  logic [3:0] start;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_target;
  logic       inc;
  logic       dec;
  logic [2:0] inc_step;
  logic [3:0] cur_val;
  logic       busy;
  logic       done;

  logic       rst_n;
  logic [3:0] cnt;

  int total = 0;
  int bad   = 0;

  counter_seeker #(.WIDTH(4), .STEP_W(3)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .start     (start),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_target(req_target),
    .inc       (inc),
    .dec       (dec),
    .inc_step  (inc_step),
    .cur_val   (cur_val),
    .busy      (busy),
    .done      (done)
  );

  // Downstream up/down counter with active-low async reset.
  assign rst_n = ~rst;
  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)   cnt <= start;
    else if (inc) cnt <= cnt + 4'(inc_step);
    else if (dec) cnt <= cnt - 4'(inc_step);
  end

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Every cycle: counter tracks the mirror, pulses are exclusive, idle step is 0.
  always @(negedge clk_in) begin
    check("cnt_mirror", 32'(cnt), 32'(cur_val));
    check("inc_dec_excl", 32'(inc & dec), 0);
    if (!inc && !dec) check("step_idle", 32'(inc_step), 0);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_req(input logic [3:0] t);
    check("ready_before_req", 32'(req_ready), 1);
    req_target = t;
    req_valid  = 1'b1;
    tick();
    req_valid  = 1'b0;
    check("plan_busy", 32'(busy), 1);
    check("plan_ready", 32'(req_ready), 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done), 1);
    tick();
  endtask

  task automatic pulse(input string tag, input logic i, input logic d, input logic [2:0] s);
    check({tag, "_inc"}, 32'(inc), 32'(i));
    check({tag, "_dec"}, 32'(dec), 32'(d));
    check({tag, "_step"}, 32'(inc_step), 32'(s));
  endtask

  initial begin
    rst = 1'b1; start = 4'd5; req_valid = 1'b0; req_target = 4'd0;
    #3;
    check("rst_cur", 32'(cur_val), 5);
    check("rst_ready", 32'(req_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    pulse("rst", 1'b0, 1'b0, 3'd0);
    @(posedge clk_in); #1;
    rst = 1'b0;
    tick();
    check("idle_cur", 32'(cur_val), 5);

    // 5 -> 2: dec 3
    do_req(4'd2); wait_done();
    check("pos2", 32'(cur_val), 2);

    // 2 -> 12: dec 6, done 3 cycles after handshake
    do_req(4'd12);
    check("a_plan_nopulse", 32'(inc | dec), 0);
    tick(); pulse("a_p1", 1'b0, 1'b1, 3'd6);
    check("a_p1_cur", 32'(cur_val), 2);
    tick(); check("a_done", 32'(done), 1);
    check("a_cur", 32'(cur_val), 12);
    pulse("a_done", 1'b0, 1'b0, 3'd0);
    tick(); check("a_ready", 32'(req_ready), 1);
    check("a_done_clr", 32'(done), 0);
    check("a_busy_clr", 32'(busy), 0);

    // 12 -> 0: inc 4
    do_req(4'd0); wait_done();
    check("pos0", 32'(cur_val), 0);

    // 0 -> 8 tie: inc 7 then inc 1
    do_req(4'd8);
    tick(); pulse("b_p1", 1'b1, 1'b0, 3'd7);
    tick(); pulse("b_p2", 1'b1, 1'b0, 3'd1);
    check("b_mid_cur", 32'(cur_val), 7);
    tick(); check("b_done", 32'(done), 1);
    check("b_cur", 32'(cur_val), 8);
    tick(); check("b_ready", 32'(req_ready), 1);

    // 8 -> 14: inc 6
    do_req(4'd14); wait_done();
    check("pos14", 32'(cur_val), 14);

    // 14 -> 1: inc 3 through 15 and 0
    do_req(4'd1);
    tick(); pulse("c_p1", 1'b1, 1'b0, 3'd3);
    tick(); check("c_done", 32'(done), 1);
    check("c_cur", 32'(cur_val), 1);
    tick();

    // 1 -> 3 then 3 -> 3: no pulse, done in cycle E2
    do_req(4'd3); wait_done();
    do_req(4'd3);
    tick(); check("d_done", 32'(done), 1);
    pulse("d_nopulse", 1'b0, 1'b0, 3'd0);
    check("d_cur", 32'(cur_val), 3);
    tick(); check("d_ready", 32'(req_ready), 1);

    // 3 -> 11 with req_valid kept high and target changing while busy
    do_req(4'd11);
    req_valid = 1'b1; req_target = 4'd5;
    tick(); pulse("e_p1", 1'b1, 1'b0, 3'd7);
    check("e_ready_p1", 32'(req_ready), 0);
    req_target = 4'd9;
    tick(); pulse("e_p2", 1'b1, 1'b0, 3'd1);
    req_target = 4'd13;
    tick(); check("e_done", 32'(done), 1);
    check("e_cur", 32'(cur_val), 11);
    tick(); check("e_ready", 32'(req_ready), 1);
    check("e_idle_busy", 32'(busy), 0);
    tick(); check("e_accept", 32'(busy), 1);
    req_valid = 1'b0;
    tick(); pulse("e_next", 1'b1, 1'b0, 3'd2);
    tick(); check("e_next_cur", 32'(cur_val), 13);
    tick();

    // 13 -> 0, then reset during the second pulse of 0 -> 8
    do_req(4'd0); wait_done();
    do_req(4'd8);
    tick(); tick();
    pulse("f_p2", 1'b1, 1'b0, 3'd1);
    #2 rst = 1'b1;
    #1;
    pulse("f_rst", 1'b0, 1'b0, 3'd0);
    check("f_rst_cur", 32'(cur_val), 5);
    check("f_rst_cnt", 32'(cnt), 5);
    check("f_rst_ready", 32'(req_ready), 1);
    check("f_rst_busy", 32'(busy), 0);
    #3 rst = 1'b0;
    tick();
    check("f_idle_ready", 32'(req_ready), 1);
    check("f_idle_cur", 32'(cur_val), 5);
    check("f_idle_cnt", 32'(cnt), 5);
    do_req(4'd5);
    tick(); check("f_zero_done", 32'(done), 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/counter_seeker.md
# counter_seeker

Sequencer that drives an up/down counter from its current value to a requested target. It issues single-cycle `inc`/`dec` pulses with a step size on `inc_step`. It keeps a registered mirror of the counter value, takes targets over a valid/ready handshake, and always moves the short way round the modular range. It sits upstream of the up/down counter block, connected port-for-port to that counter's `inc`, `dec` and `inc_step` inputs.

## Interface
- `WIDTH`, 4: value width, matches the counter.
- `STEP_W`, 3: step field width; `MAX_STEP` = 2^STEP_W − 1 (7 at default).

Ports:
- `clk_in` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in WIDTH: value loaded into the mirror while `rst` is high. It is the same value the counter loads at its reset.
- `req_valid` in 1: target request valid.
- `req_ready` out 1: block can accept a target.
- `req_target` in WIDTH: requested final value.
- `inc` out 1: increment pulse to the counter.
- `dec` out 1: decrement pulse to the counter.
- `inc_step` out STEP_W: step magnitude for the current pulse; 0 when no pulse.
- `cur_val` out WIDTH: mirror of the counter value.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a request completes.

## Operation
- States: IDLE, PLAN, STEP, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch `req_target`, go to PLAN.
- PLAN, for one cycle, computes modulo 2^WIDTH:
  - up = target − cur_val; down = cur_val − target.
  - dir = DEC if down < up, else INC. A tie goes INC.
  - rem = min(up, down).
  - If rem = 0, go to DONE with no pulses. Otherwise go to STEP.
- STEP: each cycle emits one pulse:
  - `inc`=1 (dir INC) or `dec`=1 (dir DEC), with `inc_step` = min(rem, MAX_STEP).
  - At the edge ending the cycle: rem −= step; `cur_val` ± step, wrapping mod 2^WIDTH.
  - Leave for DONE when rem reaches 0.
- DONE: `done`=1 for one cycle, then return to IDLE.
- Invariants:
  - `inc` and `dec` are never both high.
  - `inc_step`=0 whenever neither is high.
  - `cur_val` changes only at the end of a pulse cycle, so it equals the counter value at every edge.
- `req_valid` is ignored outside IDLE. `req_target` is sampled only at the handshake edge.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `req_ready`=1, `inc`=`dec`=0, `inc_step`=0, `busy`=0, `done`=0, `cur_val`=`start`.
- Handshake is sampled at edge E0.
  - Cycle after E0: PLAN, with `busy`=1 and `req_ready`=0.
  - Pulses occupy cycles E2 … E2+k−1 back-to-back, where k = ceil(rem/MAX_STEP).
  - `done` is high in cycle E2+k. `req_ready` is high again in cycle E2+k+1.
- rem = 0: `done` in cycle E2; no pulse is issued.
- Worst case at defaults: rem = 8 (half range), k = 2, total 5 cycles from handshake to ready.
- `rst` asserted mid-operation:
  - Immediately aborts: pulses drop asynchronously, state goes to IDLE, `cur_val`=`start`.
  - The counter reloads `start` on the same reset, so the pair stays consistent.
- Wrap-around is fully modular, e.g. 14 → 1 is INC by 3, passing 15 and 0.

## Structure
- Shared package `counter_pkg` holds:
  - The state enum {IDLE, PLAN, STEP, DONE}.
  - The direction enum {DIR_INC, DIR_DEC}.
  - The `MAX_STEP` derivation from `STEP_W`.
  - Default widths `WIDTH`=4 and `STEP_W`=3, shared with the counter.
- No sub-module: the modular-distance logic is a few subtractions and stays inline.
- The bench instantiates `counter_seeker` with the up/down counter, tying the counter's active-low reset input to the inverse of `rst` and its start-value input to the same `start` signal.
- The bench checks counter value == `cur_val` every cycle.

## Test plan
- Reset with `start`=5 → `cur_val`=5, `req_ready`=1, `inc`=`dec`=0, `inc_step`=0, `busy`=0.
- cur 2, target 12 → one `dec` pulse with `inc_step`=6; `done` 3 cycles after handshake; `cur_val`=12.
- cur 0, target 8 (tie) → `inc` 7 then `inc` 1 in consecutive cycles; `cur_val`=8; `done` in cycle E4.
- cur 14, target 1 → single `inc` with step 3 (wraps); cur 3, target 3 → no pulse, `done` in cycle E2.
- `req_valid` held high with changing `req_target` during STEP → ignored; next target accepted only when `req_ready`=1.
- `rst` pulsed during second pulse of a 0→8 move → `inc` drops immediately, `cur_val`=`start`, counter matches, IDLE on release.
